mod_12_ud_tracker: RTL and testbench

- Receive-side companion to the team's mod-12 up/down counter.
- Samples a 4-bit count stream from a mod-12 up/down counter and recovers the counting direction that produced it.
- Flags wrap events, detects illegal values and illegal jumps, and keeps a signed lap count.
- Sits on the consumer end of any counter link, e.g. a position, hour or phase counter crossing into a monitor block.

---
 rtl/mod12_pkg.sv | 25 ++
 rtl/mod_n_step_classifier.sv | 48 ++++
 rtl/mod_12_ud_tracker.sv | 185 ++++++++++++++++++
 tb/tb_mod_12_ud_tracker.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mod12_pkg.sv
// Shared types and defaults for the mod-12 counter family.
// Holds:
//   MOD_N_DEF, W_DEF : default modulus and count width
//   state_t          : tracker FSM states
//   step_t           : classification of one count-to-count step
package mod12_pkg;

  localparam int MOD_N_DEF = 12;
  localparam int W_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN,
    STEP_JUMP,
    STEP_ILLEGAL
  } step_t;

endpackage

// File: rtl/mod_n_step_classifier.sv
// Purely combinational step classifier for a mod-N counter stream.
// Compares a new sample against the previous legal sample and reports
// what kind of step it was, plus whether that step crossed the wrap point.
// Ports:
//   prev  in  W   previous legal sample
//   q_in  in  W   new sample
//   step  out     step class (HOLD/UP/DOWN/JUMP/ILLEGAL)
//   wrap  out 1   step is UP from MOD_N-1 to 0, or DOWN from 0 to MOD_N-1
module mod_n_step_classifier
  import mod12_pkg::*;
#(
  parameter int MOD_N = MOD_N_DEF,
  parameter int W     = W_DEF
) (
  input  logic [W-1:0] prev,
  input  logic [W-1:0] q_in,
  output step_t        step,
  output logic         wrap
);

  localparam logic [W-1:0] TOP = W'(MOD_N - 1);

  logic [W-1:0] up_val;
  logic [W-1:0] dn_val;
  logic         illegal;

  // One extra bit so MOD_N == 2^W still compares correctly.
  assign illegal = ({1'b0, q_in} >= (W+1)'(MOD_N));
  assign up_val  = (prev == TOP) ? '0 : prev + 1'b1;
  assign dn_val  = (prev == '0) ? TOP : prev - 1'b1;

  always_comb begin
    step = STEP_JUMP;
    wrap = 1'b0;
    if (illegal) begin
      step = STEP_ILLEGAL;
    end else if (q_in == prev) begin
      step = STEP_HOLD;
    end else if (q_in == up_val) begin
      step = STEP_UP;
      wrap = (prev == TOP);
    end else if (q_in == dn_val) begin
      step = STEP_DOWN;
      wrap = (prev == '0);
    end
  end

endmodule

// File: rtl/mod_12_ud_tracker.sv
// Receive-side tracker for a mod-N up/down counter stream.
// Recovers the counting direction, declares lock after LOCK_N consistent
// steps, flags wraps and errors, and keeps a signed lap count.
// Ports:
//   clk         in  1  clock, rising edge
//   rst         in  1  synchronous active-high reset
//   q_in        in  W  sampled count value
//   q_valid     in  1  q_in carries a sample this cycle
//   dir         out 1  recovered direction (1 = up, 0 = down)
//   locked      out 1  tracker is in LOCKED
//   wrap_pulse  out 1  one-cycle pulse on a legal wrap step
//   err_pulse   out 1  one-cycle pulse on an illegal value or jump
//   lap_count   out 8  signed lap counter, wraps modulo 256
//   err_count   out 8  error counter, saturates at 255
module mod_12_ud_tracker
  import mod12_pkg::*;
#(
  parameter int MOD_N  = MOD_N_DEF,
  parameter int W      = W_DEF,
  parameter int LOCK_N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] q_in,
  input  logic         q_valid,
  output logic         dir,
  output logic         locked,
  output logic         wrap_pulse,
  output logic         err_pulse,
  output logic [7:0]   lap_count,
  output logic [7:0]   err_count
);

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

  function automatic logic [3:0] sat_inc_run(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc_cnt(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  function automatic logic signed [7:0] lap_step(input logic signed [7:0] v,
                                                 input logic up);
    return up ? v + 8'sd1 : v - 8'sd1;
  endfunction

  // Registered state
  state_t              state_p1;
  logic [W-1:0]        prev_p1;
  logic [3:0]          run_p1;
  logic                dir_p1;
  logic                wrap_p1;
  logic                err_p1;
  logic signed [7:0]   lap_p1;
  logic [7:0]          errc_p1;

  // Next-state values
  state_t              state_nxt;
  logic [W-1:0]        prev_nxt;
  logic [3:0]          run_nxt;
  logic                dir_nxt;
  logic                wrap_nxt;
  logic                err_nxt;
  logic signed [7:0]   lap_nxt;
  logic [7:0]          errc_nxt;

  step_t               step;
  logic                step_wrap;
  logic                step_up;

  mod_n_step_classifier #(
    .MOD_N (MOD_N),
    .W     (W)
  ) u_classifier (
    .prev (prev_p1),
    .q_in (q_in),
    .step (step),
    .wrap (step_wrap)
  );

  assign step_up = (step == STEP_UP);

  // Stage p0 -> p1: FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Stage p0 -> p1: tracking and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_p1 <= '0;
      run_p1  <= '0;
      dir_p1  <= 1'b1;
      wrap_p1 <= 1'b0;
      err_p1  <= 1'b0;
      lap_p1  <= '0;
      errc_p1 <= '0;
    end else begin
      prev_p1 <= prev_nxt;
      run_p1  <= run_nxt;
      dir_p1  <= dir_nxt;
      wrap_p1 <= wrap_nxt;
      err_p1  <= err_nxt;
      lap_p1  <= lap_nxt;
      errc_p1 <= errc_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    prev_nxt  = prev_p1;
    run_nxt   = run_p1;
    dir_nxt   = dir_p1;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    lap_nxt   = lap_p1;
    errc_nxt  = errc_p1;
    if (q_valid) begin
      if (state_p1 == IDLE) begin
        // Only legality matters here; prev is not meaningful yet.
        if (step == STEP_ILLEGAL) begin
          err_nxt = 1'b1;
        end else begin
          prev_nxt  = q_in;
          run_nxt   = '0;
          state_nxt = ACQ;
        end
      end else begin
        case (step)
          STEP_UP, STEP_DOWN: begin
            prev_nxt = q_in;
            // run==0 means no direction established yet, so any step extends.
            if ((step_up == dir_p1) || (run_p1 == '0)) begin
              run_nxt = sat_inc_run(run_p1);
            end else begin
              run_nxt   = 4'd1;
              state_nxt = ACQ;
            end
            dir_nxt = step_up;
            if (run_nxt >= LOCK_RUN) begin
              state_nxt = LOCKED;
            end
            if (step_wrap) begin
              wrap_nxt = 1'b1;
              lap_nxt  = lap_step(lap_p1, step_up);
            end
          end
          STEP_JUMP: begin
            err_nxt   = 1'b1;
            prev_nxt  = q_in;
            run_nxt   = '0;
            state_nxt = ACQ;
          end
          STEP_ILLEGAL: begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
          default: begin
          end
        endcase
      end
      if (err_nxt) begin
        errc_nxt = sat_inc_cnt(errc_p1);
      end
    end
  end

  // Output decode
  always_comb begin
    locked = (state_p1 == LOCKED);
  end

  assign dir        = dir_p1;
  assign wrap_pulse = wrap_p1;
  assign err_pulse  = err_p1;
  assign lap_count  = lap_p1;
  assign err_count  = errc_p1;

endmodule

// File: tb/tb_mod_12_ud_tracker.sv
// Directed testbench for mod_12_ud_tracker with hand-computed expectations.
module tb_mod_12_ud_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q_in = '0;
  logic       q_valid = 1'b0;
  logic       dir;
  logic       locked;
  logic       wrap_pulse;
  logic       err_pulse;
  logic [7:0] lap_count;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  mod_12_ud_tracker #(
    .MOD_N  (12),
    .W      (4),
    .LOCK_N (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .q_in       (q_in),
    .q_valid    (q_valid),
    .dir        (dir),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .lap_count  (lap_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [3:0] v);
    q_valid = 1'b1;
    q_in    = v;
    @(posedge clk);
    #1;
    q_valid = 1'b0;
  endtask

  task automatic gap();
    q_valid = 1'b0;
    q_in    = 4'd7;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    q_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_dir", dir, 1);
    chk("rst_locked", locked, 0);
    chk("rst_wrap", wrap_pulse, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_lap", lap_count, 8'h00);
    chk("rst_errc", err_count, 8'h00);

    // Up acquisition 0,1,2,3
    smp(4'd0); chk("acq0_locked", locked, 0); chk("acq0_err", err_pulse, 0);
    smp(4'd1); chk("acq1_locked", locked, 0); chk("acq1_err", err_pulse, 0);
    smp(4'd2); chk("acq2_locked", locked, 0); chk("acq2_err", err_pulse, 0);
    smp(4'd3); chk("acq3_locked", locked, 1); chk("acq3_dir", dir, 1);
    chk("acq3_err", err_pulse, 0);

    // Locked up stream through the wrap point
    for (int v = 4; v <= 9; v++) begin
      smp(4'(v));
      chk("up_nowrap", wrap_pulse, 0);
    end
    smp(4'd10); chk("up10_wrap", wrap_pulse, 0);
    smp(4'd11); chk("up11_wrap", wrap_pulse, 0);
    smp(4'd0);  chk("up0_wrap", wrap_pulse, 1); chk("up0_lap", lap_count, 8'h01);
    smp(4'd1);  chk("up1_wrap", wrap_pulse, 0); chk("up1_lap", lap_count, 8'h01);
    chk("up1_locked", locked, 1);

    // q_valid=0 gaps hold state; 2 must still be a legal up step after
    gap(); chk("gap1_locked", locked, 1); chk("gap1_err", err_pulse, 0);
    gap(); chk("gap2_wrap", wrap_pulse, 0); chk("gap2_dir", dir, 1);
    smp(4'd2); chk("postgap_err", err_pulse, 0); chk("postgap_locked", locked, 1);

    // Reversal while locked, then relock downwards
    smp(4'd3); smp(4'd4); smp(4'd5);
    chk("rev_pre_locked", locked, 1);
    smp(4'd4); chk("rev_dir", dir, 0); chk("rev_locked", locked, 0);
    smp(4'd3); chk("rev3_locked", locked, 0);
    smp(4'd2); chk("rev2_locked", locked, 1); chk("rev2_dir", dir, 0);

    // Reset mid-lock has priority over a valid sample
    rst = 1'b1; q_valid = 1'b1; q_in = 4'd1;
    @(posedge clk); #1;
    rst = 1'b0; q_valid = 1'b0;
    chk("mrst_dir", dir, 1);
    chk("mrst_locked", locked, 0);
    chk("mrst_wrap", wrap_pulse, 0);
    chk("mrst_err", err_pulse, 0);
    chk("mrst_lap", lap_count, 8'h00);

    // Down stream 2,1,0,11,10
    smp(4'd2);  chk("dn2_locked", locked, 0);
    smp(4'd1);  chk("dn1_dir", dir, 0); chk("dn1_locked", locked, 0);
    smp(4'd0);  chk("dn0_locked", locked, 0); chk("dn0_wrap", wrap_pulse, 0);
    smp(4'd11); chk("dn11_locked", locked, 1); chk("dn11_wrap", wrap_pulse, 1);
    chk("dn11_lap", lap_count, 8'hFF);
    smp(4'd10); chk("dn10_wrap", wrap_pulse, 0); chk("dn10_lap", lap_count, 8'hFF);
    chk("dn10_dir", dir, 0);

    // Illegal value mid-stream, then a jump
    smp(4'd13); chk("ill_err", err_pulse, 1); chk("ill_errc", err_count, 8'd1);
    chk("ill_locked", locked, 0);
    gap(); chk("ill_err_1cyc", err_pulse, 0);
    smp(4'd3); chk("idle_load_err", err_pulse, 0); chk("idle_load_errc", err_count, 8'd1);
    smp(4'd7); chk("jump_err", err_pulse, 1); chk("jump_errc", err_count, 8'd2);
    smp(4'd8); chk("jump8_err", err_pulse, 0); chk("jump8_locked", locked, 0);
    chk("jump8_dir", dir, 1);
    smp(4'd9); chk("jump9_locked", locked, 0);
    smp(4'd10); chk("jump10_locked", locked, 1);

    // Wrap step that is also a reversal
    smp(4'd11); smp(4'd0);
    chk("rw_up_wrap", wrap_pulse, 1); chk("rw_up_lap", lap_count, 8'h00);
    smp(4'd11);
    chk("rw_wrap", wrap_pulse, 1); chk("rw_lap", lap_count, 8'hFF);
    chk("rw_locked", locked, 0); chk("rw_dir", dir, 0);

    // Lap counter rolls over from 127 to -128
    do_reset();
    smp(4'd0);
    for (int i = 1; i <= 127 * 12; i++) begin
      smp(4'(i % 12));
    end
    chk("lap_127", lap_count, 8'h7F);
    for (int v = 1; v <= 11; v++) begin
      smp(4'(v));
    end
    smp(4'd0);
    chk("lap_m128", lap_count, 8'h80); chk("lap_m128_wrap", wrap_pulse, 1);

    // Error counter saturates at 255 (illegal samples while IDLE)
    do_reset();
    for (int i = 0; i < 254; i++) begin
      smp(4'd14);
    end
    chk("errc_254", err_count, 8'd254);
    smp(4'd15); chk("errc_255", err_count, 8'd255); chk("errc_255_pulse", err_pulse, 1);
    smp(4'd12); chk("errc_sat", err_count, 8'd255); chk("errc_sat_locked", locked, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
